cdl_rx_crc16_check: RTL and testbench
=====================================

# cdl_rx_crc16_check

Receive-side CRC16 checker and payload de-framer for the USB bulk endpoint. It takes the destuffed, NRZI-decoded bit stream from the RX path, least significant bit first, one bit per `bit_valid` strobe. It runs the USB CRC16 (x^16+x^15+x^2+1) over the whole DATA field, forwards payload bytes with the trailing two CRC bytes removed, and reports CRC and length status at end of packet. It is the counterpart of the TX-side CDL_CRC_16 generator.

## Interface
- `MAX_BYTES`, default 1026: maximum DATA field bytes, payload plus CRC.
- `COUNT_W`, default 11: width of the byte counter and `payload_len`.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `bit_valid`  in  1: `data_bit` is valid this cycle; low on stuffed-bit and idle cycles.
- `data_bit`  in  1: serial data, LSB of each byte first.
- `sop`  in  1: one-cycle start-of-DATA-field strobe.
- `eop`  in  1: one-cycle end-of-packet strobe.
- `rx_byte`  out  8: forwarded payload byte.
- `rx_byte_valid`  out  1: one-cycle qualifier for `rx_byte`.
- `crc_ok`  out  1: one-cycle pulse, residue correct and length legal.
- `crc_err`  out  1: one-cycle pulse, residue wrong and length legal.
- `len_err`  out  1: one-cycle pulse, illegal length.
- `payload_len`  out  COUNT_W: payload byte count (total bytes − 2), valid from the status pulse until the next `sop`.
- `busy`  out  1: high in the RECV state.

## Operation
- States:
  - IDLE: bits and `eop` ignored. `sop` → RECV.
  - RECV: `eop` → DONE. `sop` → RECV, restarting the packet with no status pulse.
  - DONE: one cycle, status pulse issued, then → IDLE. A `sop` in DONE is honoured and → RECV.
- On `sop`:
  - `crc` ← 16'hFFFF.
  - Bit counter, byte counter and byte pipeline are cleared.
  - If `bit_valid` is high in the same cycle, that bit is the first packet bit and is processed against 16'hFFFF.
- CRC update per valid bit `b`: `fb = b ^ crc[15]`; `crc ← {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 16'h0000)`.
- Byte assembly: bits shift in LSB first. After 8 valid bits, a byte is complete and the byte counter increments, saturating at MAX_BYTES+1.
- Byte forwarding uses a two-byte delay pipeline (stage0, stage1):
  - On each byte completion, if two bytes are already held, stage1 is emitted on `rx_byte`.
  - Bytes are then shifted along the pipeline.
  - The two bytes left in the pipeline at `eop` are the CRC field and are never forwarded.
  - Forwarding stops once the byte count exceeds MAX_BYTES.
- Status is evaluated on the `eop` cycle and registered:
  - `len_err` if the bit count is not a multiple of 8, the byte count is < 2, or the byte count is > MAX_BYTES.
  - Otherwise, residue `crc == 16'h800D` → `crc_ok`, else `crc_err`.
  - Exactly one of the three outputs pulses per packet.
- `eop` and `bit_valid` in the same cycle: the bit is dropped and `eop` wins.
- `payload_len` = byte count − 2 when length is legal, else 0.

## Timing
- All outputs are registered.
- Reset values: `rx_byte`=0, `rx_byte_valid`=0, `crc_ok`=0, `crc_err`=0, `len_err`=0, `payload_len`=0, `busy`=0, state IDLE, `crc`=16'hFFFF.
- `rx_byte_valid` asserts the cycle after the `bit_valid` edge that completes byte k+2, carrying byte k.
- Status pulse: the cycle after `eop`. `busy` falls in the same cycle.
- Back-to-back packets: a `sop` one cycle after `eop` is legal. The previous status still pulses.
- `rst` mid-packet: all outputs drop asynchronously to their reset values. No status is issued for the aborted packet.
- Idle gaps (`bit_valid` low) inside RECV are legal and of any length. They do not change CRC or counters.

## Test plan
- Zero-length DATA: `sop`, bytes 00 00, `eop` → `crc_ok` one cycle after `eop`; `payload_len`=0; no `rx_byte_valid`.
- Payload 00 01 02 03 followed by the inverted CRC from the bench model, LSB byte first:
  - → four `rx_byte_valid` pulses carrying 00, 01, 02, 03 in order;
  - → `crc_ok`, `payload_len`=4.
- Same packet with bit 0 of byte 2 flipped → bytes still forwarded; `crc_err` pulses; `crc_ok` stays 0.
- 13 valid bits then `eop` → `len_err`, `payload_len`=0. A single byte then `eop` → `len_err`.
- Random `bit_valid` gaps of 0–5 cycles, plus `sop` re-issued mid-packet after 20 bits:
  - → no status for the aborted packet;
  - → the second packet checks `crc_ok`.
- `rst` asserted for 1 cycle mid-byte → all outputs 0 within the same cycle; the next full packet → `crc_ok`.

Source files
------------

// File: rtl/cdl_rx_crc16_check.sv
// Receive-side USB CRC16 checker and payload de-framer.
// Consumes the destuffed serial DATA field LSB first, forwards payload bytes
// with the trailing two CRC bytes held back, and issues one status pulse per packet.
module cdl_rx_crc16_check #(
    parameter int MAX_BYTES = 1026,
    parameter int COUNT_W   = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_valid,
    input  logic               data_bit,
    input  logic               sop,
    input  logic               eop,
    output logic [7:0]         rx_byte,
    output logic               rx_byte_valid,
    output logic               crc_ok,
    output logic               crc_err,
    output logic               len_err,
    output logic [COUNT_W-1:0] payload_len,
    output logic               busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0]        CRC_INIT    = 16'hFFFF;
    localparam logic [15:0]        CRC_RESIDUE = 16'h800D;
    localparam logic [COUNT_W-1:0] MAX_C       = COUNT_W'(MAX_BYTES);
    localparam logic [COUNT_W-1:0] SAT_C       = COUNT_W'(MAX_BYTES + 1);

    logic [1:0]         state_q, state_d;
    logic [15:0]        crc_q, crc_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [COUNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [6:0]         shreg_q, shreg_d;
    logic [7:0]         stage0_q, stage0_d, stage1_q, stage1_d;
    logic [1:0]         held_q, held_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic               rx_vld_q, rx_vld_d;
    logic               ok_q, ok_d, err_q, err_d, lerr_q, lerr_d;
    logic [COUNT_W-1:0] plen_q, plen_d;
    logic               busy_q, busy_d;
    logic               len_bad;
    logic [7:0]         new_byte;

    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Next-state: sop restarts from any state; eop closes a packet and wins over a same-cycle bit.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        stage0_d   = stage0_q;
        stage1_d   = stage1_q;
        held_d     = held_q;
        rx_byte_d  = rx_byte_q;
        rx_vld_d   = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        lerr_d     = 1'b0;
        plen_d     = plen_q;
        new_byte   = {data_bit, shreg_q};
        len_bad    = (bit_cnt_q != 3'd0) || (byte_cnt_q < COUNT_W'(2)) || (byte_cnt_q > MAX_C);

        if (sop) begin
            state_d    = S_RECV;
            crc_d      = CRC_INIT;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            shreg_d    = '0;
            held_d     = 2'd0;
            plen_d     = '0;
            if (bit_valid) begin
                crc_d     = crc_next(CRC_INIT, data_bit);
                shreg_d   = {data_bit, 6'd0};
                bit_cnt_d = 3'd1;
            end
        end else begin
            case (state_q)
                S_RECV: begin
                    if (eop) begin
                        state_d = S_DONE;
                        if (len_bad) begin
                            lerr_d = 1'b1;
                            plen_d = '0;
                        end else begin
                            ok_d   = (crc_q == CRC_RESIDUE);
                            err_d  = (crc_q != CRC_RESIDUE);
                            plen_d = byte_cnt_q - COUNT_W'(2);
                        end
                    end else if (bit_valid) begin
                        crc_d     = crc_next(crc_q, data_bit);
                        shreg_d   = {data_bit, shreg_q[6:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q != SAT_C) byte_cnt_d = byte_cnt_q + COUNT_W'(1);
                            // Oldest held byte is known payload once a third byte lands behind it.
                            if (held_q == 2'd2 && byte_cnt_q < MAX_C) begin
                                rx_byte_d = stage1_q;
                                rx_vld_d  = 1'b1;
                            end
                            stage1_d = stage0_q;
                            stage0_d = new_byte;
                            if (held_q != 2'd2) held_d = held_q + 2'd1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_RECV);
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            crc_q      <= CRC_INIT;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            stage0_q   <= '0;
            stage1_q   <= '0;
            held_q     <= 2'd0;
            rx_byte_q  <= '0;
            rx_vld_q   <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            lerr_q     <= 1'b0;
            plen_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            stage0_q   <= stage0_d;
            stage1_q   <= stage1_d;
            held_q     <= held_d;
            rx_byte_q  <= rx_byte_d;
            rx_vld_q   <= rx_vld_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            lerr_q     <= lerr_d;
            plen_q     <= plen_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_vld_q;
    assign crc_ok        = ok_q;
    assign crc_err       = err_q;
    assign len_err       = lerr_q;
    assign payload_len   = plen_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cdl_rx_crc16_check.sv
// Directed bench for cdl_rx_crc16_check with a byte/status scoreboard.
module tb_cdl_rx_crc16_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_valid = 1'b0, data_bit = 1'b0, sop = 1'b0, eop = 1'b0;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid, crc_ok, crc_err, len_err, busy;
    logic [10:0] payload_len;

    cdl_rx_crc16_check #(.MAX_BYTES(1026), .COUNT_W(11)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .data_bit(data_bit),
        .sop(sop), .eop(eop), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err),
        .payload_len(payload_len), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;   // {len_err, crc_err, crc_ok}
        logic [10:0] len;
    } stat_t;

    localparam logic [2:0] K_OK  = 3'b001;
    localparam logic [2:0] K_ERR = 3'b010;
    localparam logic [2:0] K_LEN = 3'b100;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_bytes[$];
    stat_t       exp_stat[$];
    logic [7:0]  frame[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every forwarded byte and every status pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_byte_valid) begin
                checks++;
                assert (exp_bytes.size() != 0) else begin
                    errors++;
                    $error("FAIL byte_unexpected: observed %0h expected none", rx_byte);
                end
                if (exp_bytes.size() != 0) chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_bytes.pop_front()});
            end
            if (crc_ok || crc_err || len_err) begin
                checks++;
                assert (exp_stat.size() != 0) else begin
                    errors++;
                    $error("FAIL status_unexpected: observed %b expected none", {len_err, crc_err, crc_ok});
                end
                if (exp_stat.size() != 0) begin
                    stat_t s;
                    s = exp_stat.pop_front();
                    chk("status_kind", {29'd0, len_err, crc_err, crc_ok}, {29'd0, s.kind});
                    chk("payload_len", {21'd0, payload_len}, {21'd0, s.len});
                    chk("busy_at_status", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        return (c[15] ^ b) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    endfunction

    // One clock of stimulus, then inputs return to idle.
    task automatic drive(input logic s, input logic e, input logic bv, input logic db);
        sop = s; eop = e; bit_valid = bv; data_bit = db;
        @(posedge clk); #1;
        sop = 1'b0; eop = 1'b0; bit_valid = 1'b0; data_bit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic b, input int maxgap);
        idle(maxgap == 0 ? 0 : int'($urandom_range(0, maxgap)));
        drive(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic send_byte(input logic [7:0] v, input int maxgap);
        for (int j = 0; j < 8; j++) send_bit(v[j], maxgap);
    endtask

    // Append the inverted CRC, most significant register bit transmitted first.
    task automatic append_crc();
        logic [15:0] c;
        logic [7:0]  b0, b1;
        c = 16'hFFFF;
        foreach (frame[i]) for (int j = 0; j < 8; j++) c = crc_upd(c, frame[i][j]);
        c = ~c;
        for (int j = 0; j < 8; j++) begin
            b0[j] = c[15-j];
            b1[j] = c[7-j];
        end
        frame.push_back(b0);
        frame.push_back(b1);
    endtask

    task automatic expect_fwd();
        for (int i = 0; i < frame.size() - 2; i++) exp_bytes.push_back(frame[i]);
    endtask

    task automatic expect_status(input logic [2:0] k, input int len);
        stat_t s;
        s.kind = k;
        s.len  = 11'(len);
        exp_stat.push_back(s);
    endtask

    task automatic send_frame(input int maxgap, input logic bit_on_eop);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        foreach (frame[i]) send_byte(frame[i], maxgap);
        drive(1'b0, 1'b1, bit_on_eop, 1'b1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_rx_byte_valid", {31'd0, rx_byte_valid}, 32'd0);
        chk("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
        chk("rst_crc_err", {31'd0, crc_err}, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        chk("rst_payload_len", {21'd0, payload_len}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Zero-length DATA field; a bit coincident with eop must be dropped
        frame = '{8'h00, 8'h00};
        expect_status(K_OK, 0);
        send_frame(0, 1'b1);
        idle(3);

        // Payload 00..03, then back-to-back the same packet with one bit flipped
        frame = '{8'h00, 8'h01, 8'h02, 8'h03};
        append_crc();
        expect_fwd();
        expect_status(K_OK, 4);
        send_frame(0, 1'b0);
        frame[2] = frame[2] ^ 8'h01;
        expect_fwd();
        expect_status(K_ERR, 4);
        send_frame(2, 1'b0);
        idle(3);

        // 13 bits then eop
        expect_status(K_LEN, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) send_bit(1'(i % 3 == 0), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Single byte then eop
        expect_status(K_LEN, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Aborted packet (20 bits, sop re-issued) then a gappy good packet
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 5);
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(8'($urandom_range(0, 255)));
        append_crc();
        expect_fwd();
        expect_status(K_OK, 6);
        send_frame(5, 1'b0);
        idle(3);

        // Reset mid-byte: outputs clear immediately, then a clean packet
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) send_bit(1'(i % 2), 0);
        chk("busy_mid_packet", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_status", {29'd0, len_err, crc_err, crc_ok}, 32'd0);
        chk("midrst_rx", {23'd0, rx_byte_valid, rx_byte}, 32'd0);
        chk("midrst_payload_len", {21'd0, payload_len}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        frame = '{8'h5A, 8'hC3, 8'h7E};
        append_crc();
        expect_fwd();
        expect_status(K_OK, 3);
        send_frame(1, 1'b0);
        idle(5);

        chk("bytes_left", exp_bytes.size(), 32'd0);
        chk("status_left", exp_stat.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
